// File: rtl/mod5_serial_framer.sv
// Serial-to-parallel framer: packs FRAME_W bits MSB-first and tracks the remainder mod 5
// bit by bit, presenting the frame and its verdict on a valid/ready output.
module mod5_serial_framer #(
  parameter int FRAME_W = 6
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               bit_in,
  input  logic               bit_valid,
  output logic               bit_ready,
  input  logic               flush,
  output logic [FRAME_W-1:0] word_out,
  output logic               word_valid,
  input  logic               word_ready,
  output logic               mult5_out,
  output logic [2:0]         rem_out,
  output logic [4:0]         bit_cnt,
  output logic [2:0]         state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // Producers hold valid (and data) until ready; ready never depends on valid.

  typedef enum logic [2:0] {
    R0   = 3'd0,
    R1   = 3'd1,
    R2   = 3'd2,
    R3   = 3'd3,
    R4   = 3'd4,
    HOLD = 3'd5
  } state_t;

  localparam logic [4:0] LAST = 5'(FRAME_W - 1);

  state_t             state;
  logic [FRAME_W-1:0] shift;
  logic [2:0]         r_nxt;

  // Appending bit b to a value with remainder r gives remainder (2r + b) mod 5.
  function automatic logic [2:0] next_rem(input logic [2:0] r, input logic b);
    logic [3:0] s;
    s = {r, 1'b0} + {3'b000, b};
    if (s >= 4'd5) s = s - 4'd5;
    return s[2:0];
  endfunction

  assign r_nxt     = next_rem(state, bit_in);
  assign bit_ready = (state != HOLD);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= R0;
      bit_cnt    <= 5'd0;
      shift      <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      mult5_out  <= 1'b0;
      rem_out    <= 3'd0;
    end else begin
      case (state)
        HOLD: begin
          // Completed frame is held; flush cannot discard it.
          if (word_ready) begin
            word_valid <= 1'b0;
            state      <= R0;
          end
        end
        default: begin
          if (flush) begin
            state   <= R0;
            bit_cnt <= 5'd0;
            shift   <= '0;
          end else if (bit_valid) begin
            if (bit_cnt == LAST) begin
              word_out   <= {shift[FRAME_W-2:0], bit_in};
              rem_out    <= r_nxt;
              mult5_out  <= (r_nxt == 3'd0);
              word_valid <= 1'b1;
              bit_cnt    <= 5'd0;
              shift      <= '0;
              state      <= HOLD;
            end else begin
              shift   <= {shift[FRAME_W-2:0], bit_in};
              bit_cnt <= bit_cnt + 5'd1;
              state   <= state_t'(r_nxt);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod5_serial_framer.sv
// Directed bench for mod5_serial_framer: vector table of frames plus hand sequences
// for backpressure, flush, reset and an exhaustive 6-bit sweep with gaps.
module tb_mod5_serial_framer;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rstn;
  logic         bit_in;
  logic         bit_valid;
  logic         bit_ready;
  logic         flush;
  logic [W-1:0] word_out;
  logic         word_valid;
  logic         word_ready;
  logic         mult5_out;
  logic [2:0]   rem_out;
  logic [4:0]   bit_cnt;
  logic [2:0]   state_dbg;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  typedef struct {
    logic [W-1:0] frame;
    logic [W-1:0] exp_word;
    logic         exp_m5;
    logic [2:0]   exp_rem;
    int           max_gap;
  } vec_t;

  vec_t vecs[9];

  mod5_serial_framer #(.FRAME_W(W)) dut (
    .clk(clk), .rstn(rstn), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .flush(flush), .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
    .mult5_out(mult5_out), .rem_out(rem_out), .bit_cnt(bit_cnt), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // driver tasks
  task automatic send_bit(input logic b);
    int waited;
    waited = 0;
    bit_in    = b;
    bit_valid = 1'b1;
    while (bit_ready !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    if (waited >= 20) check("bit_ready_timeout", 32'(bit_ready), 32'd1);
    tick();
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Sends one frame, checks the verdict, then completes the output handshake.
  task automatic send_frame(input logic [W-1:0] frame, input logic [W-1:0] exp_word,
                            input logic exp_m5, input logic [2:0] exp_rem, input int max_gap);
    logic [W-1:0] f;
    f = frame;
    for (int i = W - 1; i >= 0; i--) begin
      if (max_gap > 0) idle($urandom_range(max_gap, 0));
      send_bit(f[i]);
    end
    check("word_valid", 32'(word_valid), 32'd1);
    check("word_out", 32'(word_out), 32'(exp_word));
    check("mult5_out", 32'(mult5_out), 32'(exp_m5));
    check("rem_out", 32'(rem_out), 32'(exp_rem));
    check("hold_bit_ready", 32'(bit_ready), 32'd0);
    if (max_gap > 0) idle($urandom_range(2, 0));
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    check("post_hs_valid", 32'(word_valid), 32'd0);
    check("post_hs_ready", 32'(bit_ready), 32'd1);
  endtask

  initial begin
    logic [W-1:0] f;
    rstn = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; flush = 1'b0; word_ready = 1'b0;

    vecs[0] = '{6'd10, 6'b001010, 1'b1, 3'd0, 0};
    vecs[1] = '{6'd63, 6'b111111, 1'b0, 3'd3, 0};
    vecs[2] = '{6'd0,  6'b000000, 1'b1, 3'd0, 0};
    vecs[3] = '{6'd45, 6'b101101, 1'b1, 3'd0, 2};
    vecs[4] = '{6'd7,  6'b000111, 1'b0, 3'd2, 2};
    vecs[5] = '{6'd38, 6'b100110, 1'b0, 3'd3, 1};
    vecs[6] = '{6'd1,  6'b000001, 1'b0, 3'd1, 0};
    vecs[7] = '{6'd44, 6'b101100, 1'b0, 3'd4, 3};
    vecs[8] = '{6'd32, 6'b100000, 1'b0, 3'd2, 1};

    idle(2);
    check("rst_word_valid", 32'(word_valid), 32'd0);
    check("rst_word_out", 32'(word_out), 32'd0);
    check("rst_mult5", 32'(mult5_out), 32'd0);
    check("rst_rem", 32'(rem_out), 32'd0);
    check("rst_bit_cnt", 32'(bit_cnt), 32'd0);
    rstn = 1'b1;
    tick();
    check("rel_bit_ready", 32'(bit_ready), 32'd1);

    // Back-to-back frame with word_ready already high: one bubble.
    word_ready = 1'b1;
    f = 6'b001010;
    for (int i = W - 1; i >= 0; i--) send_bit(f[i]);
    check("t1_valid", 32'(word_valid), 32'd1);
    check("t1_word", 32'(word_out), 32'd10);
    check("t1_mult5", 32'(mult5_out), 32'd1);
    check("t1_rem", 32'(rem_out), 32'd0);
    check("t1_ready_bubble", 32'(bit_ready), 32'd0);
    tick();
    check("t1_valid_drop", 32'(word_valid), 32'd0);
    check("t1_ready_back", 32'(bit_ready), 32'd1);
    check("t1_word_kept", 32'(word_out), 32'd10);
    word_ready = 1'b0;

    for (int v = 0; v < 9; v++)
      send_frame(vecs[v].frame, vecs[v].exp_word, vecs[v].exp_m5, vecs[v].exp_rem, vecs[v].max_gap);

    // Backpressure: frame 45 held for 5 cycles with stray bits and a flush.
    f = 6'd45;
    for (int i = W - 1; i >= 0; i--) send_bit(f[i]);
    for (int c = 0; c < 5; c++) begin
      bit_valid = 1'b1;
      bit_in    = c[0];
      flush     = (c == 2);
      tick();
      check("t3_valid", 32'(word_valid), 32'd1);
      check("t3_word", 32'(word_out), 32'd45);
      check("t3_mult5", 32'(mult5_out), 32'd1);
      check("t3_ready", 32'(bit_ready), 32'd0);
    end
    bit_valid = 1'b0; flush = 1'b0;
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    check("t3_release", 32'(word_valid), 32'd0);
    check("t3_bit_cnt", 32'(bit_cnt), 32'd0);
    check("t3_kept_word", 32'(word_out), 32'd45);

    // Flush of a partial frame drops the concurrent bit.
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    check("t4_cnt3", 32'(bit_cnt), 32'd3);
    flush = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    tick();
    flush = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    check("t4_flush_cnt", 32'(bit_cnt), 32'd0);
    check("t4_flush_state", 32'(state_dbg), 32'd0);
    send_frame(6'd5, 6'd5, 1'b1, 3'd0, 0);

    // Reset mid-frame.
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    rstn = 1'b0;
    tick();
    check("t5a_cnt", 32'(bit_cnt), 32'd0);
    check("t5a_word", 32'(word_out), 32'd0);
    check("t5a_valid", 32'(word_valid), 32'd0);
    rstn = 1'b1;
    tick();
    check("t5a_ready", 32'(bit_ready), 32'd1);

    // Reset while holding a completed frame.
    f = 6'd63;
    for (int i = W - 1; i >= 0; i--) send_bit(f[i]);
    check("t5b_pre_valid", 32'(word_valid), 32'd1);
    rstn = 1'b0;
    tick();
    check("t5b_valid", 32'(word_valid), 32'd0);
    check("t5b_word", 32'(word_out), 32'd0);
    check("t5b_rem", 32'(rem_out), 32'd0);
    check("t5b_mult5", 32'(mult5_out), 32'd0);
    rstn = 1'b1;
    tick();
    check("t5b_ready", 32'(bit_ready), 32'd1);

    // Exhaustive sweep with random gaps.
    for (int v = 0; v < 64; v++)
      send_frame(6'(v), 6'(v), ((v % 5) == 0), 3'(v % 5), 2);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
